hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Parametrised pipeline hazard controller for the 5-stage RV32I core.
- Detects load-use hazards and inserts bubbles for loads with a configurable result latency.
- Freezes the pipeline while data memory is busy and flushes DE/EX on taken branches.
- Generates EX-stage forwarding selects and keeps a saturating stall-cycle counter.

Parameters:
- REG_W, 5: register-index width.
- LOAD_LAT, 1: bubbles required per load-use hazard; legal range 1..4.
- CNT_W, 16: stall-counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active low.
- rs1_de, rs2_de  in  REG_W  source registers of the instruction in DE.
- rs1_used_de, rs2_used_de  in  1  the corresponding source register is actually read.
- rs1_ex, rs2_ex  in  REG_W  source registers of the instruction in EX.
- rd_ex  in  REG_W  destination register in EX.
- DMRd_ex  in  1  instruction in EX is a load.
- rd_me  in  REG_W  destination register in ME.
- regwr_me  in  1  ME writes the register file.
- rd_wb  in  REG_W  destination register in WB.
- regwr_wb  in  1  WB writes the register file.
- branch_taken_ex  in  1  branch or jump resolved taken in EX.
- dm_busy_me  in  1  data memory not ready; ME must hold.
- stall_fe, stall_de  out  1  hold the PC and the FE/DE register.
- stall_ex, stall_me  out  1  hold the DE/EX and EX/ME registers.
- flush_de  out  1  clear the FE/DE register.
- flush_ex  out  1  clear DE/EX (bubble insert).
- fwd_a_ex, fwd_b_ex  out  2  operand select: 00 register file, 01 WB, 10 ME.
- stall_cnt  out  CNT_W  total stalled cycles, saturating.

Behaviour:
- One clock, clk. Reset is synchronous and active-low (rst_n).
- Reset:
  - While rst_n=0: every stall/flush output is 0, fwd_* is 00, state becomes IDLE, bubble counter bcnt is 0, stall_cnt is 0.
  - Reset mid-stall abandons the stall.
- Load-use condition LU:
  - LU = DMRd_ex & (rd_ex != 0) & ((rs1_used_de & rd_ex == rs1_de) | (rs2_used_de & rd_ex == rs2_de)).
  - x0 never causes a hazard.
- FSM states: IDLE, LU_STALL, MEM_WAIT. All outputs are combinational from the current state and inputs.
- Priority per cycle: dm_busy_me > branch_taken_ex > LU / LU_STALL.
- dm_busy_me=1, any state:
  - stall_fe = stall_de = stall_ex = stall_me = 1; flush_* = 0.
  - bcnt is frozen. The state saved in ret_state is resumed after busy drops.
  - Reported state is MEM_WAIT. Exit happens the cycle after dm_busy_me falls, back to ret_state with bcnt unchanged.
- branch_taken_ex=1 and not busy:
  - flush_de = flush_ex = 1; no stalls.
  - Next state is IDLE and bcnt is 0. A pending load-use stall is cancelled.
- IDLE with LU (not busy, no branch):
  - stall_fe = stall_de = flush_ex = 1.
  - If LOAD_LAT > 1: next state LU_STALL, bcnt = LOAD_LAT-1.
  - Otherwise stay in IDLE.
- LU_STALL:
  - stall_fe = stall_de = flush_ex = 1 each cycle; bcnt decrements.
  - When bcnt reaches 1, the next state is IDLE.
  - Total bubbles for one hazard = LOAD_LAT exactly.
  - LU is not re-evaluated in LU_STALL, because EX holds a bubble.
- Forwarding (combinational, independent of FSM):
  - fwd_a_ex = 10 if regwr_me & rd_me != 0 & rd_me == rs1_ex.
  - Else 01 if regwr_wb & rd_wb != 0 & rd_wb == rs1_ex.
  - Else 00. fwd_b_ex is identical using rs2_ex. ME has priority over WB.
- stall_cnt:
  - Increments on each clock with stall_fe=1 and rst_n=1.
  - Saturates at 2^CNT_W-1; no wrap.
- X handling: an X on any input must not propagate X into the state registers. The bench checks this only after reset.

Test Plan:
- LOAD_LAT=1; lw x5 in EX (DMRd_ex=1, rd_ex=5), rs1_de=5, rs1_used_de=1 -> one cycle of stall_fe=stall_de=flush_ex=1, then 0; stall_cnt=1.
- LOAD_LAT=3, same hazard -> exactly 3 consecutive bubble cycles; stall_cnt=3; state returns to IDLE.
- rd_ex=0 with rs1_de=0, load in EX; or rs2_de match with rs2_used_de=0 -> no stall.
- LOAD_LAT=3, branch_taken_ex=1 in the 2nd bubble cycle -> flush_de=flush_ex=1 that cycle, no further bubbles, bcnt=0.
- dm_busy_me high for 4 cycles during LU_STALL (bcnt=2) -> all four stalls high, no flush for 4 cycles, then 2 remaining bubbles; stall_cnt advances by 6.
- rd_me=rd_wb=7, both regwr=1, rs1_ex=7 -> fwd_a_ex=10. Drop regwr_me -> 01. rd_me=rd_wb=0 -> 00. Assert rst_n=0 mid-stall -> next cycle all outputs 0, stall_cnt=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: load-use bubbles,
// memory-busy freeze, branch flush, EX forwarding selects and stall counter.
module hazard_ctrl #(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] rs1_de,
    input  logic [REG_W-1:0] rs2_de,
    input  logic             rs1_used_de,
    input  logic             rs2_used_de,
    input  logic [REG_W-1:0] rs1_ex,
    input  logic [REG_W-1:0] rs2_ex,
    input  logic [REG_W-1:0] rd_ex,
    input  logic             DMRd_ex,
    input  logic [REG_W-1:0] rd_me,
    input  logic             regwr_me,
    input  logic [REG_W-1:0] rd_wb,
    input  logic             regwr_wb,
    input  logic             branch_taken_ex,
    input  logic             dm_busy_me,
    output logic             stall_fe,
    output logic             stall_de,
    output logic             stall_ex,
    output logic             stall_me,
    output logic             flush_de,
    output logic             flush_ex,
    output logic [1:0]       fwd_a_ex,
    output logic [1:0]       fwd_b_ex,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam logic [2:0] BCNT_INIT = 3'(LOAD_LAT - 1);

    state_e           state_q, state_d;
    state_e           ret_state_q, ret_state_d;
    state_e           eff_state;
    logic [2:0]       bcnt_q, bcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             lu;

    // Load-use detection; x0 never creates a dependency
    always_comb begin
        lu = 1'b0;
        if (DMRd_ex && (rd_ex != '0)) begin
            if ((rs1_used_de && (rd_ex == rs1_de)) || (rs2_used_de && (rd_ex == rs2_de)))
                lu = 1'b1;
        end
    end

    // Hazard FSM next-state and stall/flush outputs.
    // The cycle busy drops still shows MEM_WAIT but already acts as the saved
    // state, so the resumed bubbles follow the freeze without a gap.
    always_comb begin
        state_d     = state_q;
        ret_state_d = ret_state_q;
        bcnt_d      = bcnt_q;
        stall_fe    = 1'b0;
        stall_de    = 1'b0;
        stall_ex    = 1'b0;
        stall_me    = 1'b0;
        flush_de    = 1'b0;
        flush_ex    = 1'b0;
        eff_state   = (state_q == MEM_WAIT) ? ret_state_q : state_q;
        if (rst_n) begin
            if (dm_busy_me) begin
                stall_fe = 1'b1;
                stall_de = 1'b1;
                stall_ex = 1'b1;
                stall_me = 1'b1;
                state_d  = MEM_WAIT;
                if (state_q != MEM_WAIT)
                    ret_state_d = state_q;
            end else if (branch_taken_ex) begin
                flush_de = 1'b1;
                flush_ex = 1'b1;
                state_d  = IDLE;
                bcnt_d   = '0;
            end else if (eff_state == LU_STALL) begin
                stall_fe = 1'b1;
                stall_de = 1'b1;
                flush_ex = 1'b1;
                bcnt_d   = bcnt_q - 3'd1;
                state_d  = (bcnt_q <= 3'd1) ? IDLE : LU_STALL;
            end else begin
                state_d = IDLE;
                if (lu) begin
                    stall_fe = 1'b1;
                    stall_de = 1'b1;
                    flush_ex = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = LU_STALL;
                        bcnt_d  = BCNT_INIT;
                    end
                end
            end
        end
    end

    // Saturating count of cycles with the front end held
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_fe && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // Forwarding selects: ME result has priority over WB
    always_comb begin
        fwd_a_ex = 2'b00;
        fwd_b_ex = 2'b00;
        if (rst_n) begin
            if (regwr_me && (rd_me != '0) && (rd_me == rs1_ex))
                fwd_a_ex = 2'b10;
            else if (regwr_wb && (rd_wb != '0) && (rd_wb == rs1_ex))
                fwd_a_ex = 2'b01;
            if (regwr_me && (rd_me != '0) && (rd_me == rs2_ex))
                fwd_b_ex = 2'b10;
            else if (regwr_wb && (rd_wb != '0) && (rd_wb == rs2_ex))
                fwd_b_ex = 2'b01;
        end
    end

    // State, saved state, bubble counter and stall counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ret_state_q <= IDLE;
            bcnt_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ret_state_q <= ret_state_d;
            bcnt_q      <= bcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
